// File: rtl/load_store_unit.sv
// Memory-stage load/store controller: address alignment, load extension, sub-word stores as read-modify-write.
// Optional build macro LSU_PERF_CNT_EN adds perf_loads / perf_stores / perf_rmw_stalls counters.
module load_store_unit #(
    parameter int XLEN      = 64,
    parameter int MEM_BYTES = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_read,
    input  logic            req_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] mem_read_data,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_write_data,
    output logic            mem_write,
    output logic            mem_read,
    output logic [XLEN-1:0] load_data,
    output logic            stall,
    output logic            fault,
    output logic            fault_sticky
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_loads,
    output logic [31:0]     perf_stores,
    output logic [31:0]     perf_rmw_stalls
`endif
);

    // state  | meaning
    // IDLE   | accept loads, SD, and the read half of sub-word stores
    // RMW_WR | write back the merged doubleword of a sub-word store
    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t          state;
    logic [XLEN-1:0] merge_q;
    logic [XLEN-1:0] rmw_addr_q;

    logic [2:0]      off;
    logic [5:0]      bit_shift;
    logic [XLEN-1:0] aligned;
    logic [1:0]      size;
    logic            is_store;
    logic            is_load;
    logic            req_any;
    logic            misaligned;
    logic            out_of_range;
    logic            illegal;
    logic            fault_c;
    logic            ok_load;
    logic            ok_sd;
    logic            ok_sub;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_ext;
    logic [XLEN-1:0] width_mask;
    logic [XLEN-1:0] byte_mask;
    logic [XLEN-1:0] merge_d;

    assign off       = addr[2:0];
    assign bit_shift = {off, 3'b000};
    assign aligned   = {addr[XLEN-1:3], 3'b000};
    assign size      = funct3[1:0];
    assign is_store  = req_write;
    assign is_load   = req_read & ~req_write;
    assign req_any   = (req_read | req_write) && (state == IDLE);

    always_comb begin
        misaligned = 1'b0;
        case (size)
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = |off[1:0];
            2'b11:   misaligned = |off;
            default: misaligned = 1'b0;
        endcase
    end

    // Extra top bit keeps the +7 from wrapping near the top of the address space.
    assign out_of_range = ({1'b0, aligned} + (XLEN+1)'(7)) >= (XLEN+1)'(MEM_BYTES);
    assign illegal      = is_store ? funct3[2] : (funct3 == 3'b111);
    assign fault_c      = req_any & (misaligned | out_of_range | illegal);

    assign ok_load = req_any & is_load & ~fault_c;
    assign ok_sd   = req_any & is_store & ~fault_c & (size == 2'b11);
    assign ok_sub  = req_any & is_store & ~fault_c & (size != 2'b11);

    assign shifted = mem_read_data >> bit_shift;

    always_comb begin
        load_ext   = '0;
        width_mask = '0;
        case (size)
            2'b00: begin
                load_ext   = funct3[2] ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                       : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
                width_mask = {{(XLEN-8){1'b0}}, 8'hFF};
            end
            2'b01: begin
                load_ext   = funct3[2] ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                       : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
                width_mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
            end
            2'b10: begin
                load_ext   = funct3[2] ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                       : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
                width_mask = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
            end
            default: begin
                load_ext   = shifted;
                width_mask = '1;
            end
        endcase
    end

    assign byte_mask = width_mask << bit_shift;
    assign merge_d   = (mem_read_data & ~byte_mask) | ((store_data << bit_shift) & byte_mask);

    always_comb begin
        mem_address    = '0;
        mem_write_data = '0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        load_data      = '0;
        stall          = 1'b0;
        fault          = 1'b0;
        if (!reset) begin
            if (state == RMW_WR) begin
                mem_address    = rmw_addr_q;
                mem_write_data = merge_q;
                mem_write      = 1'b1;
            end else begin
                mem_address    = aligned;
                mem_read       = ok_load | ok_sub;
                mem_write      = ok_sd;
                mem_write_data = ok_sd ? store_data : '0;
                load_data      = ok_load ? load_ext : '0;
                stall          = ok_sub;
                fault          = fault_c;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            merge_q      <= '0;
            rmw_addr_q   <= '0;
            fault_sticky <= 1'b0;
        end else begin
            if (fault_c) fault_sticky <= 1'b1;
            case (state)
                IDLE: begin
                    if (ok_sub) begin
                        merge_q    <= merge_d;
                        rmw_addr_q <= aligned;
                        state      <= RMW_WR;
                    end
                end
                RMW_WR:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LSU_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_loads      <= '0;
            perf_stores     <= '0;
            perf_rmw_stalls <= '0;
        end else begin
            if (ok_load)                      perf_loads      <= perf_loads + 32'd1;
            if (ok_sd || (state == RMW_WR))   perf_stores     <= perf_stores + 32'd1;
            if (ok_sub)                       perf_rmw_stalls <= perf_rmw_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: constant vector table, directed multi-cycle sequences, and random ops
// checked against a byte-array memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_read, req_write;
    logic [2:0]  funct3;
    logic [63:0] addr, store_data, mem_read_data;
    logic [63:0] mem_address, mem_write_data, load_data;
    logic        mem_write, mem_read, stall, fault, fault_sticky;
`ifdef LSU_PERF_CNT_EN
    logic [31:0] perf_loads, perf_stores, perf_rmw_stalls;
`endif

    load_store_unit dut (
        .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .mem_read_data(mem_read_data), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_write(mem_write), .mem_read(mem_read),
        .load_data(load_data), .stall(stall), .fault(fault), .fault_sticky(fault_sticky)
`ifdef LSU_PERF_CNT_EN
        , .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_rmw_stalls(perf_rmw_stalls)
`endif
    );

    always #5 clk = ~clk;

    // Data memory the DUT talks to, plus a bench-side port for preloading.
    logic [7:0]  mem [64];
    logic        tb_wr = 1'b0;
    int          tb_addr = 0;
    logic [63:0] tb_data = '0;

    always @(posedge clk) begin
        if (mem_write) begin
            for (int j = 0; j < 8; j++) mem[int'(mem_address[5:0]) + j] <= mem_write_data[8*j +: 8];
        end else if (tb_wr) begin
            for (int j = 0; j < 8; j++) mem[tb_addr + j] <= tb_data[8*j +: 8];
        end
    end

    always_comb begin
        mem_read_data = '0;
        if (mem_address < 64)
            for (int j = 0; j < 8; j++) mem_read_data[8*j +: 8] = mem[int'(mem_address[5:0]) + j];
    end

    // Reference model: architectural byte memory updated per completed store.
    logic [7:0] ref_mem [64];
    logic       sticky_exp;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic ref_fault(input logic rd, input logic wr, input logic [2:0] f3,
                                       input logic [63:0] a);
        int  n;
        logic mis, oor, ill;
        if (!(rd || wr)) return 1'b0;
        n   = nbytes(f3);
        mis = (a % 64'(n)) != 0;
        oor = ((a & ~64'd7) + 64'd7) >= 64'd64;
        ill = wr ? f3[2] : (f3 == 3'b111);
        return mis | oor | ill;
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] a);
        int n;
        logic [63:0] v;
        n = nbytes(f3);
        v = '0;
        for (int i = 0; i < n; i++) v = v | (64'(ref_mem[int'(a) + i]) << (8*i));
        if (!f3[2] && n < 8 && v[8*n-1]) v = v | ((~64'd0) << (8*n));
        return v;
    endfunction

    function automatic logic [63:0] ref_merge(input logic [2:0] f3, input logic [63:0] a,
                                              input logic [63:0] sd);
        int n, off, base;
        logic [63:0] v;
        n    = nbytes(f3);
        off  = int'(a % 64'd8);
        base = int'(a) - off;
        v    = '0;
        for (int j = 0; j < 8; j++)
            if (j >= off && j < off + n) v[8*j +: 8] = 8'(sd >> (8*(j - off)));
            else                         v[8*j +: 8] = ref_mem[base + j];
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] sd);
        for (int i = 0; i < nbytes(f3); i++) ref_mem[int'(a) + i] = 8'(sd >> (8*i));
    endtask

    function automatic logic [63:0] mem_dword(input int a);
        logic [63:0] v;
        for (int j = 0; j < 8; j++) v[8*j +: 8] = mem[a + j];
        return v;
    endfunction

    task automatic idle_inputs();
        req_read = 1'b0; req_write = 1'b0; funct3 = 3'b000; addr = '0; store_data = '0;
    endtask

    task automatic preload(input int a, input logic [63:0] d);
        @(negedge clk);
        tb_wr = 1'b1; tb_addr = a; tb_data = d;
        for (int i = 0; i < 8; i++) ref_mem[a + i] = d[8*i +: 8];
        @(negedge clk);
        tb_wr = 1'b0;
    endtask

    // One instruction, checked against the model; holds the request through a read-modify-write.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] sd);
        logic        e_fault, e_store, e_sub, e_load;
        logic [63:0] e_ld, e_merge;
        e_fault = ref_fault(rd, wr, f3, a);
        e_store = wr & ~e_fault;
        e_sub   = e_store & (f3[1:0] != 2'b11);
        e_load  = rd & ~wr & ~e_fault;
        e_ld    = e_load ? ref_load(f3, a) : '0;
        e_merge = e_sub ? ref_merge(f3, a, sd) : '0;
        @(negedge clk);
        req_read = rd; req_write = wr; funct3 = f3; addr = a; store_data = sd;
        #1;
        chk("sticky", 64'(fault_sticky), 64'(sticky_exp));
        chk("fault", 64'(fault), 64'(e_fault));
        chk("mem_read", 64'(mem_read), 64'(e_load | e_sub));
        chk("mem_write", 64'(mem_write), 64'(e_store & ~e_sub));
        chk("stall", 64'(stall), 64'(e_sub));
        chk("load_data", load_data, e_ld);
        if (e_store && !e_sub) chk("sd_data", mem_write_data, sd);
        if (e_fault) sticky_exp = 1'b1;
        if (e_sub) begin
            @(negedge clk);
            #1;
            chk("rmw_we", 64'(mem_write), 64'd1);
            chk("rmw_addr", mem_address, a & ~64'd7);
            chk("rmw_data", mem_write_data, e_merge);
            chk("rmw_stall", 64'(stall), 64'd0);
        end
        if (e_store) ref_store(f3, a, sd);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] a;
        logic        e_fault;
        logic        e_mrd;
        logic [63:0] e_ld;
    } vec_t;

    vec_t tbl [19];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 3'b000, 64'd8,  1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0};
        tbl[1]  = '{1'b1, 1'b0, 3'b100, 64'd8,  1'b0, 1'b1, 64'h0000_0000_0000_00F0};
        tbl[2]  = '{1'b1, 1'b0, 3'b001, 64'd8,  1'b0, 1'b1, 64'h0000_0000_0000_56F0};
        tbl[3]  = '{1'b1, 1'b0, 3'b001, 64'd14, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_8000};
        tbl[4]  = '{1'b1, 1'b0, 3'b101, 64'd14, 1'b0, 1'b1, 64'h0000_0000_0000_8000};
        tbl[5]  = '{1'b1, 1'b0, 3'b010, 64'd12, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000};
        tbl[6]  = '{1'b1, 1'b0, 3'b110, 64'd12, 1'b0, 1'b1, 64'h0000_0000_8000_0000};
        tbl[7]  = '{1'b1, 1'b0, 3'b010, 64'd8,  1'b0, 1'b1, 64'h0000_0000_1234_56F0};
        tbl[8]  = '{1'b1, 1'b0, 3'b011, 64'd8,  1'b0, 1'b1, 64'h8000_0000_1234_56F0};
        tbl[9]  = '{1'b1, 1'b0, 3'b000, 64'd15, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80};
        tbl[10] = '{1'b1, 1'b0, 3'b010, 64'd6,  1'b1, 1'b0, 64'd0};
        tbl[11] = '{1'b1, 1'b0, 3'b011, 64'd64, 1'b1, 1'b0, 64'd0};
        tbl[12] = '{1'b1, 1'b0, 3'b001, 64'd9,  1'b1, 1'b0, 64'd0};
        tbl[13] = '{1'b1, 1'b0, 3'b111, 64'd8,  1'b1, 1'b0, 64'd0};
        tbl[14] = '{1'b0, 1'b1, 3'b100, 64'd8,  1'b1, 1'b0, 64'd0};
        tbl[15] = '{1'b1, 1'b0, 3'b000, 64'd64, 1'b1, 1'b0, 64'd0};
        tbl[16] = '{1'b0, 1'b1, 3'b011, 64'd60, 1'b1, 1'b0, 64'd0};
        tbl[17] = '{1'b1, 1'b1, 3'b111, 64'd8,  1'b1, 1'b0, 64'd0};
        tbl[18] = '{1'b0, 1'b0, 3'b011, 64'd8,  1'b0, 1'b0, 64'd0};

        sticky_exp = 1'b0;
        idle_inputs();
        reset = 1'b1;
        // Outputs forced low under reset even with a live faulting request.
        req_read = 1'b1; funct3 = 3'b010; addr = 64'd6;
        #1;
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_mem_read", 64'(mem_read), 64'd0);
        chk("rst_sticky", 64'(fault_sticky), 64'd0);
        chk("rst_addr", mem_address, 64'd0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) preload(8*i, {$urandom, $urandom});

        // SD commits the same cycle.
        @(negedge clk);
        req_write = 1'b1; funct3 = 3'b011; addr = 64'd16; store_data = 64'h1122_3344_5566_7788;
        #1;
        chk("sd_we", 64'(mem_write), 64'd1);
        chk("sd_addr", mem_address, 64'd16);
        chk("sd_stall", 64'(stall), 64'd0);
        ref_store(3'b011, 64'd16, 64'h1122_3344_5566_7788);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("sd_mem", mem_dword(16), 64'h1122_3344_5566_7788);

        // SB read-modify-write.
        preload(8, 64'h1);
        @(negedge clk);
        req_write = 1'b1; funct3 = 3'b000; addr = 64'd9; store_data = 64'hAB;
        #1;
        chk("sb_stall0", 64'(stall), 64'd1);
        chk("sb_rd0", 64'(mem_read), 64'd1);
        chk("sb_addr0", mem_address, 64'd8);
        @(negedge clk);
        #1;
        chk("sb_we1", 64'(mem_write), 64'd1);
        chk("sb_addr1", mem_address, 64'd8);
        chk("sb_data1", mem_write_data, 64'h0000_0000_0000_AB01);
        chk("sb_stall1", 64'(stall), 64'd0);
        ref_store(3'b000, 64'd9, 64'hAB);
        @(negedge clk);
        idle_inputs();
        chk("sb_sticky", 64'(fault_sticky), 64'd0);

        // Constant vector table against a known doubleword at address 8.
        preload(8, 64'h8000_0000_1234_56F0);
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            req_read = tbl[i].rd; req_write = tbl[i].wr; funct3 = tbl[i].f3;
            addr = tbl[i].a; store_data = 64'hDEAD_BEEF_CAFE_F00D;
            #1;
            chk($sformatf("tbl%0d_fault", i), 64'(fault), 64'(tbl[i].e_fault));
            chk($sformatf("tbl%0d_rd", i), 64'(mem_read), 64'(tbl[i].e_mrd));
            chk($sformatf("tbl%0d_we", i), 64'(mem_write), 64'd0);
            chk($sformatf("tbl%0d_ld", i), load_data, tbl[i].e_ld);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk("sticky_set", 64'(fault_sticky), 64'd1);

        // Reset during RMW_WR aborts the write.
        preload(0, 64'h2);
        @(negedge clk);
        req_write = 1'b1; funct3 = 3'b001; addr = 64'd2; store_data = 64'hBEEF;
        #1;
        chk("sh_stall", 64'(stall), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_we", 64'(mem_write), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        #1;
        chk("abort_mem", mem_dword(0), 64'h2);
        chk("abort_sticky", 64'(fault_sticky), 64'd0);
        sticky_exp = 1'b0;
        run_op(1'b1, 1'b0, 3'b011, 64'd0, 64'd0);

        // Random traffic, mostly aligned, some out of range or illegal.
        for (int k = 0; k < 300; k++) begin
            logic        rd, wr;
            logic [2:0]  f3;
            logic [63:0] a, sd;
            rd = 1'($urandom);
            wr = ($urandom_range(0, 9) < 5);
            f3 = 3'($urandom);
            if (wr && $urandom_range(0, 3) != 0) f3[2] = 1'b0;
            a  = 64'($urandom_range(0, 71));
            if ($urandom_range(0, 3) != 0) a = a & ~64'(nbytes(f3) - 1);
            if ($urandom_range(0, 31) == 0) a = a | (64'd1 << 40);
            sd = {$urandom, $urandom};
            run_op(rd, wr, f3, a, sd);
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        #1;
        for (int i = 0; i < 8; i++) chk($sformatf("final_mem%0d", i), mem_dword(8*i),
            {ref_mem[8*i+7], ref_mem[8*i+6], ref_mem[8*i+5], ref_mem[8*i+4],
             ref_mem[8*i+3], ref_mem[8*i+2], ref_mem[8*i+1], ref_mem[8*i]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
